// File: rtl/cache_fill_unit.sv
// cache_fill_unit: miss-service stage for the 2-way, 8-set, 256-bit-line data cache.
// Accepts a miss in IDLE, optionally writes the dirty victim back, fetches the line as
// eight 32-bit beats and presents it for one cycle on fillValid.
// Build option: define CACHE_FILL_WRITEBACK_EN to include the dirty-victim writeback (WB)
// state; without it every miss goes straight to FILL and memWe/memWData stay 0.
module cache_fill_unit #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss,
    input  logic [ADDR_W-1:0]        missAddr,
    input  logic                     victimDirty,
    input  logic [23:0]              victimTag,
    input  logic [LINE_WORDS*32-1:0] victimLine,
    output logic                     busy,
    output logic                     fillValid,
    output logic [ADDR_W-1:0]        fillAddr,
    output logic [LINE_WORDS*32-1:0] fillLine,
    output logic                     memReq,
    output logic                     memWe,
    output logic [ADDR_W-1:0]        memAddr,
    output logic [31:0]              memWData,
    input  logic [31:0]              memRData,
    input  logic                     memAck
);

    typedef enum logic [2:0] {StIdle, StWb, StFill, StDone, StHold} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [26:0]               line_addr_q, line_addr_d;   // missAddr[31:5] of the line
    logic [LINE_WORDS*32-1:0]  fill_line_q, fill_line_d;
    logic                      last_beat;

    assign last_beat = (cnt_q == 3'(LINE_WORDS - 1));

`ifdef CACHE_FILL_WRITEBACK_EN
    logic [23:0]               victim_tag_q, victim_tag_d;
    logic [LINE_WORDS*32-1:0]  victim_line_q, victim_line_d;
    logic                      unused_inputs;
    assign unused_inputs = ^missAddr[4:0];
`else
    logic                      unused_inputs;
    assign unused_inputs = ^{missAddr[4:0], victimDirty, victimTag, victimLine};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; miss is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (miss) begin
`ifdef CACHE_FILL_WRITEBACK_EN
                    state_d = victimDirty ? StWb : StFill;
`else
                    state_d = StFill;
`endif
                end
            end
`ifdef CACHE_FILL_WRITEBACK_EN
            StWb: begin
                if (memAck && last_beat) begin
                    state_d = StFill;
                end
            end
`endif
            StFill: begin
                if (memAck && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: latch the miss context in IDLE, advance the beat counter on acks
    always_comb begin
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        fill_line_d = fill_line_q;
`ifdef CACHE_FILL_WRITEBACK_EN
        victim_tag_d  = victim_tag_q;
        victim_line_d = victim_line_q;
`endif
        case (state_q)
            StIdle: begin
                if (miss) begin
                    line_addr_d = missAddr[31:5];
                    cnt_d       = 3'd0;
`ifdef CACHE_FILL_WRITEBACK_EN
                    victim_tag_d  = victimTag;
                    victim_line_d = victimLine;
`endif
                end
            end
`ifdef CACHE_FILL_WRITEBACK_EN
            StWb: begin
                if (memAck) begin
                    cnt_d = cnt_q + 3'd1;   // wraps to 0 after the last write beat
                end
            end
`endif
            StFill: begin
                if (memAck) begin
                    fill_line_d[{cnt_q, 5'd0} +: 32] = memRData;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 3'd0;
            line_addr_q <= '0;
            fill_line_q <= '0;
`ifdef CACHE_FILL_WRITEBACK_EN
            victim_tag_q  <= '0;
            victim_line_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            fill_line_q <= fill_line_d;
`ifdef CACHE_FILL_WRITEBACK_EN
            victim_tag_q  <= victim_tag_d;
            victim_line_q <= victim_line_d;
`endif
        end
    end

    // Outputs decoded from registered state only; memory bus is zero when idle
    always_comb begin
        busy      = (state_q != StIdle);
        fillValid = (state_q == StDone);
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWData  = 32'd0;
        case (state_q)
`ifdef CACHE_FILL_WRITEBACK_EN
            StWb: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = {victim_tag_q, line_addr_q[2:0], cnt_q, 2'b00};
                memWData = victim_line_q[{cnt_q, 5'd0} +: 32];
            end
`endif
            StFill: begin
                memReq  = 1'b1;
                memAddr = {line_addr_q, cnt_q, 2'b00};
            end
            default: ;
        endcase
    end

    assign fillAddr = {line_addr_q, 5'b00000};
    assign fillLine = fill_line_q;

endmodule

// File: tb/tb_cache_fill_unit.sv
// Directed testbench for cache_fill_unit. Inputs change and outputs are sampled on the
// falling edge; cycle n of a transaction is the cycle after rising edge n-1, with the
// miss sampled at edge 0.
module tb_cache_fill_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  missAddr;
    logic         victimDirty;
    logic [23:0]  victimTag;
    logic [255:0] victimLine;
    logic         busy;
    logic         fillValid;
    logic [31:0]  fillAddr;
    logic [255:0] fillLine;
    logic         memReq;
    logic         memWe;
    logic [31:0]  memAddr;
    logic [31:0]  memWData;
    logic [31:0]  memRData;
    logic         memAck;

    int checks;
    int errors;

    cache_fill_unit dut (
        .clk         (clk),
        .reset       (reset),
        .miss        (miss),
        .missAddr    (missAddr),
        .victimDirty (victimDirty),
        .victimTag   (victimTag),
        .victimLine  (victimLine),
        .busy        (busy),
        .fillValid   (fillValid),
        .fillAddr    (fillAddr),
        .fillLine    (fillLine),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memRData    (memRData),
        .memAck      (memAck)
    );

    always #5 clk = ~clk;

    // Reset values, and memAck with no request in flight
    task automatic test_reset();
        reset  = 1'b1;
        miss   = 1'b0;
        memAck = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, fillValid, memReq, memWe} !== 4'b0000 || memAddr !== 32'd0 ||
            memWData !== 32'd0 || fillAddr !== 32'd0 || fillLine !== 256'd0) begin
            errors++;
            $display("FAIL reset_values: ctl=%b memAddr=%h memWData=%h fillAddr=%h line=%h, want all 0",
                     {busy, fillValid, memReq, memWe}, memAddr, memWData, fillAddr, fillLine);
        end
        reset    = 1'b0;
        memAck   = 1'b1;
        memRData = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, memReq, fillValid} !== 3'b000 || fillLine !== 256'd0) begin
                errors++;
                $display("FAIL ack_when_idle: busy/req/valid=%b line=%h, want 000 and zero line",
                         {busy, memReq, fillValid}, fillLine);
            end
        end
        memAck = 1'b0;
    endtask

    // Clean fill with zero wait states
    task automatic test_clean_fill();
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hA0 + 32'(k);
        @(negedge clk);
        missAddr    = 32'h0000_1234;
        victimDirty = 1'b0;
        miss        = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            miss = 1'b0;
            if (cyc <= 8) begin
                exp_addr = 32'h1220 + 32'(4 * (cyc - 1));
                checks++;
                if ({busy, memReq, memWe, fillValid} !== 4'b1100 || memAddr !== exp_addr ||
                    memWData !== 32'd0) begin
                    errors++;
                    $display("FAIL clean_beat cyc=%0d: ctl=%b addr=%h wdata=%h, want ctl=1100 addr=%h wdata=0",
                             cyc, {busy, memReq, memWe, fillValid}, memAddr, memWData, exp_addr);
                end
                memAck   = 1'b1;
                memRData = 32'hA0 + 32'(cyc - 1);
            end else begin
                memAck   = 1'b0;
                memRData = 32'd0;
                checks++;
                if (cyc == 9 && ({busy, memReq, memWe, fillValid} !== 4'b1001 ||
                    memAddr !== 32'd0 || fillAddr !== 32'h1220 || fillLine !== exp_line)) begin
                    errors++;
                    $display("FAIL clean_done: ctl=%b memAddr=%h fillAddr=%h line=%h, want ctl=1001 memAddr=0 fillAddr=1220 line=%h",
                             {busy, memReq, memWe, fillValid}, memAddr, fillAddr, fillLine, exp_line);
                end else if (cyc == 10 && {busy, memReq, fillValid} !== 3'b100) begin
                    errors++;
                    $display("FAIL clean_hold: busy/req/valid=%b, want 100", {busy, memReq, fillValid});
                end else if (cyc == 11 && ({busy, memReq, fillValid} !== 3'b000 ||
                    fillLine !== exp_line || fillAddr !== 32'h1220)) begin
                    errors++;
                    $display("FAIL clean_idle: busy/req/valid=%b fillAddr=%h line=%h, want 000 held line",
                             {busy, memReq, fillValid}, fillAddr, fillLine);
                end
            end
        end
    endtask

    // Memory acks every third cycle; request must hold steady between acks
    task automatic test_wait_states();
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'hA0 + 32'(k);
        @(negedge clk);
        missAddr = 32'h0000_1234;
        miss     = 1'b1;
        for (int cyc = 1; cyc <= 27; cyc++) begin
            @(negedge clk);
            miss = 1'b0;
            if (cyc <= 24) begin
                exp_addr = 32'h1220 + 32'(4 * ((cyc - 1) / 3));
                checks++;
                if ({busy, memReq, memWe, fillValid} !== 4'b1100 || memAddr !== exp_addr ||
                    memWData !== 32'd0) begin
                    errors++;
                    $display("FAIL wait_beat cyc=%0d: ctl=%b addr=%h wdata=%h, want ctl=1100 addr=%h",
                             cyc, {busy, memReq, memWe, fillValid}, memAddr, memWData, exp_addr);
                end
                memAck   = (cyc % 3 == 0);
                memRData = (cyc % 3 == 0) ? 32'hA0 + 32'((cyc - 1) / 3) : 32'hDEAD_BEEF;
            end else begin
                memAck = 1'b0;
                checks++;
                if (cyc == 25 && (fillValid !== 1'b1 || fillLine !== exp_line ||
                    fillAddr !== 32'h1220)) begin
                    errors++;
                    $display("FAIL wait_done: valid=%b fillAddr=%h line=%h, want 1 1220 %h",
                             fillValid, fillAddr, fillLine, exp_line);
                end else if (cyc != 25 && fillValid !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_valid_width cyc=%0d: valid=%b, want 0", cyc, fillValid);
                end
            end
        end
    endtask

    // Dirty victim: writeback beats when the option is built in, none otherwise
    task automatic test_writeback();
`ifdef CACHE_FILL_WRITEBACK_EN
        int wb = 8;
`else
        int wb = 0;
`endif
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_data;
        for (int k = 0; k < 8; k++) begin
            exp_line[32*k +: 32]   = 32'h5000 + 32'(k);
            victimLine[32*k +: 32] = 32'h1000 + 32'(k);
        end
        @(negedge clk);
        missAddr    = 32'h0000_0060;
        victimTag   = 24'hABCDEF;
        victimDirty = 1'b1;
        miss        = 1'b1;
        for (int cyc = 1; cyc <= wb + 11; cyc++) begin
            @(negedge clk);
            // Later input changes must not disturb the transaction
            miss        = 1'b0;
            missAddr    = 32'hFFFF_FFFF;
            victimTag   = 24'h123456;
            victimLine  = '1;
            victimDirty = 1'b0;
            if (cyc <= wb) begin
                exp_addr = 32'hABCD_EF60 + 32'(4 * (cyc - 1));
                exp_data = 32'h1000 + 32'(cyc - 1);
                checks++;
                if ({busy, memReq, memWe, fillValid} !== 4'b1110 || memAddr !== exp_addr ||
                    memWData !== exp_data) begin
                    errors++;
                    $display("FAIL wb_write cyc=%0d: ctl=%b addr=%h wdata=%h, want ctl=1110 addr=%h wdata=%h",
                             cyc, {busy, memReq, memWe, fillValid}, memAddr, memWData, exp_addr, exp_data);
                end
                memAck   = 1'b1;
                memRData = 32'hBAD0_0000;
            end else if (cyc <= wb + 8) begin
                exp_addr = 32'h60 + 32'(4 * (cyc - wb - 1));
                checks++;
                if ({busy, memReq, memWe, fillValid} !== 4'b1100 || memAddr !== exp_addr ||
                    memWData !== 32'd0) begin
                    errors++;
                    $display("FAIL wb_read cyc=%0d: ctl=%b addr=%h wdata=%h, want ctl=1100 addr=%h wdata=0",
                             cyc, {busy, memReq, memWe, fillValid}, memAddr, memWData, exp_addr);
                end
                memAck   = 1'b1;
                memRData = 32'h5000 + 32'(cyc - wb - 1);
            end else begin
                memAck = 1'b0;
                checks++;
                if (cyc == wb + 9 && (fillValid !== 1'b1 || fillAddr !== 32'h60 ||
                    fillLine !== exp_line)) begin
                    errors++;
                    $display("FAIL wb_done cyc=%0d: valid=%b fillAddr=%h line=%h, want 1 60 %h",
                             cyc, fillValid, fillAddr, fillLine, exp_line);
                end else if (cyc != wb + 9 && (fillValid !== 1'b0 || memWe !== 1'b0)) begin
                    errors++;
                    $display("FAIL wb_tail cyc=%0d: valid=%b we=%b, want 0 0", cyc, fillValid, memWe);
                end
            end
        end
    endtask

    // miss held high through busy and HOLD; the second miss uses the address seen in IDLE
    task automatic test_miss_while_busy();
        logic [31:0] exp_addr;
        @(negedge clk);
        missAddr    = 32'h0000_1234;
        victimDirty = 1'b0;
        miss        = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            if (cyc == 2) missAddr = 32'h0000_4480;
            if (cyc == 12) miss = 1'b0;
            if ((cyc >= 1 && cyc <= 8) || (cyc >= 12 && cyc <= 19)) begin
                exp_addr = (cyc <= 8) ? 32'h1220 + 32'(4 * (cyc - 1))
                                      : 32'h4480 + 32'(4 * (cyc - 12));
                checks++;
                if ({busy, memReq, memWe} !== 3'b110 || memAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL busy_beat cyc=%0d: ctl=%b addr=%h, want 110 addr=%h",
                             cyc, {busy, memReq, memWe}, memAddr, exp_addr);
                end
                memAck   = 1'b1;
                memRData = (cyc <= 8) ? 32'hC0 + 32'(cyc - 1) : 32'hD0 + 32'(cyc - 12);
            end else begin
                memAck = 1'b0;
                checks++;
                if ((cyc == 9 || cyc == 10) && (fillAddr !== 32'h1220 || memReq !== 1'b0 ||
                    busy !== 1'b1 || fillValid !== (cyc == 9))) begin
                    errors++;
                    $display("FAIL busy_first_end cyc=%0d: busy=%b req=%b valid=%b fillAddr=%h, want fillAddr=1220",
                             cyc, busy, memReq, fillValid, fillAddr);
                end else if ((cyc == 11 || cyc == 22) && (busy !== 1'b0 || memReq !== 1'b0)) begin
                    errors++;
                    $display("FAIL busy_idle cyc=%0d: busy=%b req=%b, want 0 0", cyc, busy, memReq);
                end else if (cyc == 20 && (fillValid !== 1'b1 || fillAddr !== 32'h4480 ||
                    fillLine[31:0] !== 32'hD0 || fillLine[255:224] !== 32'hD7)) begin
                    errors++;
                    $display("FAIL busy_second_done: valid=%b fillAddr=%h w0=%h w7=%h, want 1 4480 d0 d7",
                             fillValid, fillAddr, fillLine[31:0], fillLine[255:224]);
                end else if (cyc == 21 && (busy !== 1'b1 || fillValid !== 1'b0)) begin
                    errors++;
                    $display("FAIL busy_second_hold: busy=%b valid=%b, want 1 0", busy, fillValid);
                end
            end
        end
    endtask

    // Reset after the 4th ack discards the partial line; a new miss starts at word 0
    task automatic test_reset_mid_fill();
        logic [31:0] exp_addr;
        @(negedge clk);
        missAddr    = 32'h0000_1234;
        victimDirty = 1'b0;
        miss        = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            miss     = 1'b0;
            memAck   = 1'b1;
            memRData = 32'hE0 + 32'(cyc - 1);
        end
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h1230) begin
            errors++;
            $display("FAIL rst_pre: req=%b addr=%h, want 1 1230", memReq, memAddr);
        end
        reset  = 1'b1;
        memAck = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, fillValid, memReq, memWe} !== 4'b0000 || memAddr !== 32'd0 ||
            memWData !== 32'd0 || fillAddr !== 32'd0 || fillLine !== 256'd0) begin
            errors++;
            $display("FAIL rst_mid: ctl=%b memAddr=%h fillAddr=%h line=%h, want all 0",
                     {busy, fillValid, memReq, memWe}, memAddr, fillAddr, fillLine);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (fillValid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_after: valid=%b busy=%b, want 0 0", fillValid, busy);
            end
        end
        missAddr = 32'h0000_2000;
        miss     = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            miss = 1'b0;
            if (cyc <= 8) begin
                exp_addr = 32'h2000 + 32'(4 * (cyc - 1));
                checks++;
                if (memReq !== 1'b1 || memAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL rst_refill cyc=%0d: req=%b addr=%h, want 1 %h",
                             cyc, memReq, memAddr, exp_addr);
                end
                memAck   = 1'b1;
                memRData = 32'hB0 + 32'(cyc - 1);
            end else begin
                memAck = 1'b0;
                checks++;
                if (fillValid !== 1'b1 || fillAddr !== 32'h2000 || fillLine[31:0] !== 32'hB0 ||
                    fillLine[255:224] !== 32'hB7) begin
                    errors++;
                    $display("FAIL rst_refill_done: valid=%b fillAddr=%h w0=%h w7=%h, want 1 2000 b0 b7",
                             fillValid, fillAddr, fillLine[31:0], fillLine[255:224]);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        miss        = 1'b0;
        missAddr    = 32'd0;
        victimDirty = 1'b0;
        victimTag   = 24'd0;
        victimLine  = '0;
        memRData    = 32'd0;
        memAck      = 1'b0;

        test_reset();
        test_clean_fill();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        test_wait_states();
        test_writeback();
        test_miss_while_busy();
        test_reset_mid_fill();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
